// File: rtl/ledg_pkg.sv
// Shared constants and pattern helpers for the green LED-bar drivers.
// Patterns are built at MAX_LED width; callers keep the low N_LED bits.
package ledg_pkg;

   localparam int MAX_LED = 32;

   localparam logic [1:0] MODE_DIRECT = 2'd0;
   localparam logic [1:0] MODE_SLEW   = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;

   function automatic logic [MAX_LED-1:0] fault_pat(input int n);
      logic [MAX_LED-1:0] p;
      p = '0;
      for (int i = 0; i < MAX_LED; i++)
         if (i < n) p[i] = i[1];
      return p;
   endfunction

   function automatic logic [MAX_LED-1:0] reset_pat(input int n);
      logic [MAX_LED-1:0] p;
      p = '0;
      for (int i = 0; i < MAX_LED; i++)
         if (i < n) p[i] = ~i[1];
      return p;
   endfunction

   function automatic logic [MAX_LED-1:0] hold_pat(input int n);
      logic [MAX_LED-1:0] p;
      p = '0;
      for (int i = 0; i < MAX_LED; i++)
         if (i < n) p[i] = i[0];
      return p;
   endfunction

   // Codes 1..n fill from bit 0; codes n+1..2n-1 empty from bit 0.
   function automatic logic [MAX_LED-1:0] bar_decode(input int k, input int n);
      logic [MAX_LED-1:0] p;
      p = '0;
      if (k >= 2 * n) begin
         p = fault_pat(n);
      end else if (k <= n) begin
         for (int i = 0; i < MAX_LED; i++)
            if (i < k) p[i] = 1'b1;
      end else begin
         for (int i = 0; i < MAX_LED; i++)
            if (i >= k - n && i < n) p[i] = 1'b1;
      end
      return p;
   endfunction

endpackage

// File: rtl/ledg_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module ledg_tick_prescaler #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic iCLK,
   input  logic iRST_n,
   output logic oTick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n)             cnt <= '0;
      else if (cnt == CNT_MAX) cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);
   end

   assign oTick = (cnt == CNT_MAX);

endmodule

// File: rtl/ledg_bar_animator.sv
// LED-bar driver: direct, slewed or blinking level display with a hold override.
// pos tracks the shown level in every mode so switching into SLEW never jumps.
module ledg_bar_animator
   import ledg_pkg::*;
#(
   parameter int N_LED    = 10,
   parameter int LVL_W    = 5,
   parameter int TICK_DIV = 5_000_000
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   input  logic [LVL_W-1:0] iLevel,
   input  logic [1:0]       iMode,
   input  logic             iHold,
   output logic [N_LED-1:0] oLED,
   output logic             oBusy
);

   localparam logic [MAX_LED-1:0] RESET_W = reset_pat(N_LED);
   localparam logic [MAX_LED-1:0] HOLD_W  = hold_pat(N_LED);
   localparam logic [LVL_W:0]     N_CODES = (LVL_W + 1)'(2 * N_LED);

   logic               tick;
   logic               level_valid;
   logic [LVL_W-1:0]   pos;
   logic               phase;
   logic [LVL_W-1:0]   slew_pos;
   logic [MAX_LED-1:0] dec_level_w;
   logic [MAX_LED-1:0] dec_slew_w;
   logic [LVL_W-1:0]   pos_nxt;
   logic               phase_nxt;
   logic [N_LED-1:0]   led_nxt;
   logic               busy_nxt;

   ledg_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .iCLK  (iCLK),
      .iRST_n(iRST_n),
      .oTick (tick)
   );

   assign level_valid = ({1'b0, iLevel} < N_CODES);

   always_comb begin
      slew_pos = pos;
      if (tick && level_valid) begin
         if (pos < iLevel)      slew_pos = pos + LVL_W'(1);
         else if (pos > iLevel) slew_pos = pos - LVL_W'(1);
      end
   end

   // An invalid level decodes to the FAULT pattern, so dec_level covers it.
   assign dec_level_w = bar_decode(int'(iLevel), N_LED);
   assign dec_slew_w  = bar_decode(int'(slew_pos), N_LED);

   always_comb begin
      pos_nxt   = pos;
      phase_nxt = phase;
      led_nxt   = dec_level_w[N_LED-1:0];
      busy_nxt  = 1'b0;
      if (iHold) begin
         led_nxt = HOLD_W[N_LED-1:0];
      end else begin
         case (iMode)
            MODE_SLEW: begin
               pos_nxt = slew_pos;
               if (level_valid) begin
                  led_nxt  = dec_slew_w[N_LED-1:0];
                  busy_nxt = (slew_pos != iLevel);
               end
            end
            MODE_BLINK: begin
               if (level_valid) pos_nxt = iLevel;
               if (tick)        phase_nxt = ~phase;
               if (phase_nxt)   led_nxt = '0;
            end
            default: begin
               if (level_valid) pos_nxt = iLevel;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         pos   <= '0;
         phase <= 1'b0;
         oLED  <= RESET_W[N_LED-1:0];
         oBusy <= 1'b0;
      end else begin
         pos   <= pos_nxt;
         phase <= phase_nxt;
         oLED  <= led_nxt;
         oBusy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ledg_bar_animator.sv
// Directed bench for ledg_bar_animator with N_LED=10, LVL_W=5, TICK_DIV=4.
module tb_ledg_bar_animator;

   localparam logic [1:0] M_DIRECT = 2'd0;
   localparam logic [1:0] M_SLEW   = 2'd1;
   localparam logic [1:0] M_BLINK  = 2'd2;

   localparam logic [9:0] P_RESET = 10'b1100110011;
   localparam logic [9:0] P_HOLD  = 10'b1010101010;
   localparam logic [9:0] P_FAULT = 10'b0011001100;

   logic       clk;
   logic       rst_n;
   logic [4:0] level;
   logic [1:0] mode;
   logic       hold;
   logic [9:0] led;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   ledg_bar_animator #(.N_LED(10), .LVL_W(5), .TICK_DIV(4)) dut (
      .iCLK  (clk),
      .iRST_n(rst_n),
      .iLevel(level),
      .iMode (mode),
      .iHold (hold),
      .oLED  (led),
      .oBusy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset, then release so the next rising edge is edge 1 with prescaler at 0.
   task automatic start_run(input logic [1:0] m, input logic [4:0] lv);
      rst_n = 1'b0;
      mode  = m;
      level = lv;
      hold  = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [9:0] exp_bar(input int k);
      logic [9:0] ones;
      ones = 10'h3FF;
      if (k == 0)       return 10'b0;
      else if (k <= 10) return ones >> (10 - k);
      else if (k < 20)  return ones << (k - 10);
      else              return P_FAULT;
   endfunction

   logic [4:0] sw_lvl [7] = '{5'd0, 5'd10, 5'd11, 5'd13, 5'd19, 5'd20, 5'd31};
   logic [9:0] sw_exp [7] = '{10'b0000000000, 10'b1111111111, 10'b1111111110,
                              10'b1111111000, 10'b1000000000, 10'b0011001100,
                              10'b0011001100};

   initial begin
      int p;
      rst_n = 1'b1;
      level = 5'd3;
      mode  = M_DIRECT;
      hold  = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      check_val("reset_led", led, P_RESET);
      check_val("reset_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();
      check_val("direct_3", led, 10'b0000000111);

      for (int i = 0; i < 7; i++) begin
         level = sw_lvl[i];
         step();
         check_val($sformatf("direct_sweep_%0d", sw_lvl[i]), led, sw_exp[i]);
      end

      // SLEW 0 -> 5: one step on every 4th edge
      start_run(M_SLEW, 5'd5);
      for (int n = 1; n <= 20; n++) begin
         step();
         p = (n / 4 > 5) ? 5 : n / 4;
         check_val($sformatf("slew_led_e%0d", n), led, exp_bar(p));
         check_val($sformatf("slew_busy_e%0d", n), busy, (p != 5));
      end
      check_val("slew_final", led, 10'b0000011111);

      // retarget to 2 once pos reaches 3
      start_run(M_SLEW, 5'd5);
      for (int n = 1; n <= 12; n++) step();
      check_val("retarget_at3", led, 10'b0000000111);
      level = 5'd2;
      for (int n = 13; n <= 20; n++) begin
         step();
         check_val($sformatf("retarget_led_e%0d", n), led,
                   (n < 16) ? 10'b0000000111 : 10'b0000000011);
         check_val($sformatf("retarget_busy_e%0d", n), busy, (n < 16));
      end

      // hold during slew at pos 2
      start_run(M_SLEW, 5'd5);
      for (int n = 1; n <= 8; n++) step();
      check_val("hold_pre", led, 10'b0000000011);
      hold = 1'b1;
      for (int n = 9; n <= 20; n++) begin
         step();
         check_val($sformatf("hold_led_e%0d", n), led, P_HOLD);
         check_val($sformatf("hold_busy_e%0d", n), busy, 0);
      end
      hold = 1'b0;
      for (int n = 21; n <= 24; n++) begin
         step();
         check_val($sformatf("release_led_e%0d", n), led,
                   (n < 24) ? 10'b0000000011 : 10'b0000000111);
         check_val($sformatf("release_busy_e%0d", n), busy, 1);
      end

      // BLINK full bar, then blinking fault
      start_run(M_BLINK, 5'd10);
      for (int n = 1; n <= 16; n++) begin
         step();
         check_val($sformatf("blink10_e%0d", n), led,
                   ((n / 4) % 2 == 0) ? 10'b1111111111 : 10'b0);
      end
      check_val("blink_busy", busy, 0);
      start_run(M_BLINK, 5'd25);
      for (int n = 1; n <= 8; n++) begin
         step();
         check_val($sformatf("blink25_e%0d", n), led,
                   ((n / 4) % 2 == 0) ? P_FAULT : 10'b0);
      end

      // reset mid-slew at pos 7 toward 15
      start_run(M_SLEW, 5'd15);
      for (int n = 1; n <= 28; n++) step();
      check_val("midslew_pos7", led, 10'b0001111111);
      #2 rst_n = 1'b0;
      #1;
      check_val("midslew_reset_led", led, P_RESET);
      check_val("midslew_reset_busy", busy, 0);
      step();
      rst_n = 1'b1;
      for (int n = 1; n <= 64; n++) begin
         step();
         p = (n / 4 > 15) ? 15 : n / 4;
         check_val($sformatf("reslew_led_e%0d", n), led, exp_bar(p));
         check_val($sformatf("reslew_busy_e%0d", n), busy, (p != 15));
      end
      check_val("reslew_final", led, 10'b1111100000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
